cache_fill_fsm: RTL and testbench



---
 rtl/cache_pkg.sv | 13 +
 rtl/fill_word_counter.sv | 29 ++
 rtl/cache_fill_fsm.sv | 161 ++++++++++++++++
 tb/tb_cache_fill_fsm.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and block-geometry constants for the cache miss/fill controller.
package cache_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int WORDS_PER_BLOCK   = 8;
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORD_IDX_W        = $clog2(WORDS_PER_BLOCK);

endpackage

// File: rtl/fill_word_counter.sv
// Saturating up-counter with synchronous clear, enable and a terminal-count flag.
module fill_word_counter #(
  parameter int MAX_COUNT = 8,
  parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  assign at_max = (count == CNT_W'(MAX_COUNT));

  // Count register: clear wins over enable, holds once MAX_COUNT is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !at_max) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: pipelined block read from main memory, streamed into the data array.
// Optional performance counters are enabled with `define CACHE_FILL_PERF_EN.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic                               memory_data_valid,
  input  logic [DATA_W-1:0]                  memory_data,
  output logic                               fsm_busy,
  output logic                               memory_read_en,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               write_data_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] array_word_offset,
  output logic [DATA_W-1:0]                  fill_data,
  output logic                               write_tag_array
`ifdef CACHE_FILL_PERF_EN
  , output logic [15:0]                      miss_count
  , output logic [15:0]                      fill_cycles
`else
`endif
);

  localparam int IDX_W        = $clog2(WORDS_PER_BLOCK);
  localparam int ISSUE_W      = IDX_W + 1;
  localparam int WORD_BYTES   = DATA_W / 8;
  localparam int OFF_BITS     = $clog2(WORDS_PER_BLOCK * WORD_BYTES);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((2 ** OFF_BITS) - 1);

  fill_state_t        state_r;
  fill_state_t        next_state_s;
  logic [ADDR_W-1:0]  base_addr_r;
  logic               latch_s;
  logic               cnt_clr_s;
  logic               issue_en_s;
  logic               recv_en_s;
  logic [ISSUE_W-1:0] issue_cnt_s;
  logic               issue_done_s;
  logic [IDX_W-1:0]   recv_cnt_s;
  logic               recv_last_s;
  logic [ISSUE_W-1:0] addr_idx_s;

  // issue_cnt stops at WORDS_PER_BLOCK so exactly one block's worth of reads goes out.
  fill_word_counter #(.MAX_COUNT(WORDS_PER_BLOCK), .CNT_W(ISSUE_W)) u_issue_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr_s),
    .en     (issue_en_s),
    .count  (issue_cnt_s),
    .at_max (issue_done_s)
  );

  // recv_cnt terminal count marks the final word of the block.
  fill_word_counter #(.MAX_COUNT(WORDS_PER_BLOCK - 1), .CNT_W(IDX_W)) u_recv_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr_s),
    .en     (recv_en_s),
    .count  (recv_cnt_s),
    .at_max (recv_last_s)
  );

  // Address parks on the last word once issuing is done instead of running past the block.
  assign addr_idx_s        = issue_done_s ? ISSUE_W'(WORDS_PER_BLOCK - 1) : issue_cnt_s;
  assign memory_address    = base_addr_r + (ADDR_W'(addr_idx_s) * ADDR_W'(WORD_BYTES));
  assign array_word_offset = recv_cnt_s;
  assign fill_data         = memory_data;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Block base address captured on the accepted miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_addr_r <= '0;
    end else if (latch_s) begin
      base_addr_r <= miss_address & BASE_MASK;
    end else begin
      base_addr_r <= base_addr_r;
    end
  end

  // Next-state and control decode.
  always_comb begin
    next_state_s     = state_r;
    fsm_busy         = 1'b0;
    memory_read_en   = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    latch_s          = 1'b0;
    cnt_clr_s        = 1'b0;
    issue_en_s       = 1'b0;
    recv_en_s        = 1'b0;
    case (state_r)
      IDLE: begin
        fsm_busy = miss_detected;
        if (miss_detected) begin
          latch_s      = 1'b1;
          cnt_clr_s    = 1'b1;
          next_state_s = FILL;
        end else begin
          next_state_s = IDLE;
        end
      end
      FILL: begin
        fsm_busy         = 1'b1;
        memory_read_en   = !issue_done_s;
        issue_en_s       = !issue_done_s;
        write_data_array = memory_data_valid;
        recv_en_s        = memory_data_valid;
        if (memory_data_valid && recv_last_s) begin
          write_tag_array = 1'b1;
          next_state_s    = IDLE;
        end else begin
          next_state_s = FILL;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

`ifdef CACHE_FILL_PERF_EN
  // Saturating count of accepted misses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_count <= 16'h0000;
    end else if (latch_s && (miss_count != 16'hFFFF)) begin
      miss_count <= miss_count + 16'h0001;
    end else begin
      miss_count <= miss_count;
    end
  end

  // Saturating count of cycles spent filling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cycles <= 16'h0000;
    end else if ((state_r == FILL) && (fill_cycles != 16'hFFFF)) begin
      fill_cycles <= fill_cycles + 16'h0001;
    end else begin
      fill_cycles <= fill_cycles;
    end
  end
`else
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: fixed-latency memory responder plus a fill-schedule reference model.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = 16'h0000;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data = 16'h0000;
  logic        fsm_busy;
  logic        memory_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  array_word_offset;
  logic [15:0] fill_data;
  logic        write_tag_array;
`ifdef CACHE_FILL_PERF_EN
  logic [15:0] miss_count;
  logic [15:0] fill_cycles;
  int          mdl_miss = 0;
  int          mdl_cycles = 0;
`endif

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .memory_read_en    (memory_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .array_word_offset (array_word_offset),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array)
`ifdef CACHE_FILL_PERF_EN
    , .miss_count      (miss_count)
    , .fill_cycles     (fill_cycles)
`endif
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  bit          ret_v [0:4095];
  logic [15:0] ret_d [0:4095];
  logic [15:0] seed;

  // Reference model: where we are in the fixed fill schedule (k = cycles since the miss).
  bit          m_busy = 1'b0;
  int          m_k = 0;
  logic [15:0] m_base = 16'h0000;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ seed ^ {a[7:0], a[15:8]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, feed memory, advance model.
  task automatic tick(input logic miss, input logic [15:0] maddr, input logic spur_v, input logic [15:0] spur_d);
    logic        e_busy, e_rd, e_wr, e_tag;
    logic [15:0] e_addr, e_data;
    int          e_off;
    miss_detected = miss;
    miss_address  = maddr;
    if (ret_v[cyc]) begin
      memory_data_valid = 1'b1;
      memory_data       = ret_d[cyc];
    end else if (!m_busy) begin
      memory_data_valid = spur_v;
      memory_data       = spur_d;
    end else begin
      memory_data_valid = 1'b0;
      memory_data       = 16'h0000;
    end
    @(negedge clk);
    if (m_busy) begin
      e_busy = 1'b1;
      e_rd   = (m_k <= 8);
      e_addr = m_base + 16'(2 * ((m_k <= 8) ? (m_k - 1) : 7));
      e_wr   = (m_k >= 5);
      e_off  = m_k - 5;
      e_data = mem_word(m_base + 16'(2 * (m_k - 5)));
      e_tag  = (m_k == 12);
    end else begin
      e_busy = miss;
      e_rd   = 1'b0;
      e_addr = 16'h0000;
      e_wr   = 1'b0;
      e_off  = 0;
      e_data = 16'h0000;
      e_tag  = 1'b0;
    end
    chk("fsm_busy", 32'(fsm_busy), 32'(e_busy));
    chk("memory_read_en", 32'(memory_read_en), 32'(e_rd));
    chk("write_data_array", 32'(write_data_array), 32'(e_wr));
    chk("write_tag_array", 32'(write_tag_array), 32'(e_tag));
    if (m_busy) chk("memory_address", 32'(memory_address), 32'(e_addr));
    if (e_wr) begin
      chk("array_word_offset", 32'(array_word_offset), 32'(e_off));
      chk("fill_data", 32'(fill_data), 32'(e_data));
    end
    if (memory_read_en === 1'b1) begin
      ret_v[cyc + 4] = 1'b1;
      ret_d[cyc + 4] = mem_word(memory_address);
    end
    if (!m_busy && miss) begin
      m_busy = 1'b1;
      m_k    = 1;
      m_base = maddr & 16'hFFF0;
`ifdef CACHE_FILL_PERF_EN
      mdl_miss++;
`endif
    end else if (m_busy) begin
`ifdef CACHE_FILL_PERF_EN
      mdl_cycles++;
`endif
      if (m_k == 12) m_busy = 1'b0;
      else m_k++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit spur);
    for (int i = 0; i < n; i++) tick(1'b0, 16'($urandom), spur, 16'($urandom));
  endtask

  task automatic run_fill(input logic [15:0] addr, input int pulse_k, input logic [15:0] pulse_addr, input bit noise);
    tick(1'b1, addr, 1'b0, 16'h0000);
    for (int k = 1; k <= 12; k++) begin
      if (k == pulse_k) tick(1'b1, pulse_addr, 1'b0, 16'h0000);
      else tick(noise && ($urandom_range(0, 3) == 0), 16'($urandom), 1'b0, 16'h0000);
    end
  endtask

  initial begin
    seed = 16'($urandom);
    for (int i = 0; i < 4096; i++) begin
      ret_v[i] = 1'b0;
      ret_d[i] = 16'h0000;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset fsm_busy", 32'(fsm_busy), 32'd0);
    chk("reset memory_read_en", 32'(memory_read_en), 32'd0);
    chk("reset write_data_array", 32'(write_data_array), 32'd0);
    chk("reset write_tag_array", 32'(write_tag_array), 32'd0);
    chk("reset memory_address", 32'(memory_address), 32'd0);
    chk("reset array_word_offset", 32'(array_word_offset), 32'd0);
    rst = 1'b0;

    // Basic fill, immediately followed by a fill with an ignored mid-fill miss.
    run_fill(16'h1234, 0, 16'h0000, 1'b0);
    run_fill(16'h1234, 3, 16'h2000, 1'b0);
`ifdef CACHE_FILL_PERF_EN
    chk("miss_count back-to-back", 32'(miss_count), 32'd2);
    chk("fill_cycles back-to-back", 32'(fill_cycles), 32'd24);
`endif
    idle(2, 1'b0);

    // Top-of-memory block must not wrap.
    run_fill(16'hFFFF, 0, 16'h0000, 1'b0);
    idle(1, 1'b0);

    // Reset during cycle 6 of a fill.
    run_fill_partial();
    idle(2, 1'b0);
    run_fill(16'h0040, 0, 16'h0000, 1'b0);

    // Spurious returns while idle.
    for (int i = 0; i < 3; i++) tick(1'b0, 16'h0000, 1'b1, 16'hBEEF);
    run_fill(16'h7A5C, 0, 16'h0000, 1'b0);

    // Randomized addresses, gaps, idle noise and re-presented misses.
    for (int r = 0; r < 10; r++) begin
      idle($urandom_range(0, 3), 1'b1);
      run_fill(16'($urandom), 0, 16'h0000, 1'b1);
    end
    idle(2, 1'b1);
`ifdef CACHE_FILL_PERF_EN
    chk("miss_count total", 32'(miss_count), 32'(mdl_miss));
    chk("fill_cycles total", 32'(fill_cycles), 32'(mdl_cycles));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  task automatic run_fill_partial();
    tick(1'b1, 16'h5A5A, 1'b0, 16'h0000);
    for (int k = 1; k <= 5; k++) tick(1'b0, 16'h0000, 1'b0, 16'h0000);
    miss_detected = 1'b0;
    memory_data_valid = ret_v[cyc];
    memory_data = ret_d[cyc];
    #1 rst = 1'b1;
    #1;
    chk("abort fsm_busy", 32'(fsm_busy), 32'd0);
    chk("abort memory_read_en", 32'(memory_read_en), 32'd0);
    chk("abort write_data_array", 32'(write_data_array), 32'd0);
    chk("abort write_tag_array", 32'(write_tag_array), 32'd0);
    chk("abort memory_address", 32'(memory_address), 32'd0);
    chk("abort array_word_offset", 32'(array_word_offset), 32'd0);
    memory_data_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("abort no tag", 32'(write_tag_array), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = cyc; i < 4096; i++) ret_v[i] = 1'b0;
    cyc += 2;
    m_busy = 1'b0;
`ifdef CACHE_FILL_PERF_EN
    mdl_miss = 0;
    mdl_cycles = 0;
`endif
  endtask

endmodule
